// File: rtl/traffic_pkg.sv
// Shared lamp colour codes, monitor fault codes and monitor state encoding.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [2:0] FC_NONE            = 3'd0;
    localparam logic [2:0] FC_INVALID         = 3'd1;
    localparam logic [2:0] FC_CONFLICT        = 3'd2;
    localparam logic [2:0] FC_TRANSITION      = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW    = 3'd4;
    localparam logic [2:0] FC_GREEN_TIMEOUT   = 3'd5;
    localparam logic [2:0] FC_ALL_RED_TIMEOUT = 3'd6;

    typedef enum logic [1:0] {
        ST_ARMING  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

    function automatic logic colour_valid(input logic [2:0] c);
        return (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

endpackage

// File: rtl/approach_tracker.sv
// Per-approach colour history: previous colour, dwell counter, sequence and dwell checks.
// Latency: check flags are combinational on the current sample; state updates on load/advance.
// Backpressure: none; the parent decides each edge whether the sample is accepted.
import traffic_pkg::*;

module approach_tracker #(
    parameter int GREEN_MAX  = 51,
    parameter int YELLOW_MIN = 11,
    parameter int CW         = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] light,
    input  logic       load,
    input  logic       advance,
    output logic [2:0] prev,
    output logic       bad_transition,
    output logic       short_yellow,
    output logic       green_timeout
);

    localparam logic [CW-1:0] GREEN_LIM  = CW'(GREEN_MAX);
    localparam logic [CW-1:0] YELLOW_LIM = CW'(YELLOW_MIN);

    logic [CW-1:0] dwell;
    logic          changed;
    logic          legal_step;

    assign changed    = (light != prev);
    assign legal_step = ((prev == GREEN)  && (light == YELLOW)) ||
                        ((prev == YELLOW) && (light == RED))    ||
                        ((prev == RED)    && (light == GREEN));

    assign bad_transition = changed && !legal_step;
    assign short_yellow   = (prev == YELLOW) && (light == RED) && (dwell < YELLOW_LIM);
    assign green_timeout  = (prev == GREEN) && (light == GREEN) && (dwell == GREEN_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= RED;
            dwell <= '0;
        end else if (load) begin
            prev  <= light;
            dwell <= CW'(1);
        end else if (advance) begin
            prev <= light;
            if (changed) begin
                dwell <= CW'(1);
            end else if (dwell != '1) begin
                dwell <= dwell + CW'(1);
            end
        end
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Lamp-drive safety monitor: validates controller codes, forwards healthy ones, flashes red on fault.
// Latency: one register from ns_light/ew_light to lamps, fault and fault_code.
// Backpressure: none; samples every cycle, inputs ignored in FAULT except for clear qualification.
import traffic_pkg::*;

module light_conflict_monitor #(
    parameter int GREEN_MAX   = 51,
    parameter int YELLOW_MIN  = 11,
    parameter int ALL_RED_MAX = 4,
    parameter int FLASH_HALF  = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    input  logic       clear_fault,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int CW = $clog2(GREEN_MAX + 2);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CW-1:0] AR_LIM     = CW'(ALL_RED_MAX);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    mon_state_t    state;
    logic [FW-1:0] flash_cnt;
    logic          flash_on;
    logic [CW-1:0] allred_cnt;

    logic [2:0] ns_prev, ew_prev;
    logic       ns_bad, ew_bad, ns_short, ew_short, ns_gto, ew_gto;
    logic       encoding_bad, conflict, inputs_ok;
    logic       all_red_now, all_red_prev, all_red_timeout;
    logic [2:0] cause;
    logic       trip, load, advance;

    assign encoding_bad = !(colour_valid(ns_light) && colour_valid(ew_light));
    assign conflict     = (ns_light != RED) && (ew_light != RED);
    assign inputs_ok    = !encoding_bad && !conflict;

    assign all_red_now     = (ns_light == RED) && (ew_light == RED);
    assign all_red_prev    = (ns_prev == RED) && (ew_prev == RED);
    assign all_red_timeout = all_red_now && all_red_prev && (allred_cnt == AR_LIM);

    always_comb begin
        cause = FC_NONE;
        if (encoding_bad)                cause = FC_INVALID;
        else if (conflict)               cause = FC_CONFLICT;
        else if (ns_bad || ew_bad)       cause = FC_TRANSITION;
        else if (ns_short || ew_short)   cause = FC_SHORT_YELLOW;
        else if (ns_gto || ew_gto)       cause = FC_GREEN_TIMEOUT;
        else if (all_red_timeout)        cause = FC_ALL_RED_TIMEOUT;
    end

    // In ARMING only encoding/conflict count; cause is then 1 or 2 whenever inputs are not ok.
    assign trip    = ((state == ST_ARMING) && !inputs_ok) ||
                     ((state == ST_MONITOR) && (cause != FC_NONE));
    assign load    = (state == ST_ARMING) && inputs_ok;
    assign advance = (state == ST_MONITOR) && (cause == FC_NONE);

    approach_tracker #(
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_MIN(YELLOW_MIN),
        .CW        (CW)
    ) u_ns (
        .clk           (clk),
        .reset_n       (reset_n),
        .light         (ns_light),
        .load          (load),
        .advance       (advance),
        .prev          (ns_prev),
        .bad_transition(ns_bad),
        .short_yellow  (ns_short),
        .green_timeout (ns_gto)
    );

    approach_tracker #(
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_MIN(YELLOW_MIN),
        .CW        (CW)
    ) u_ew (
        .clk           (clk),
        .reset_n       (reset_n),
        .light         (ew_light),
        .load          (load),
        .advance       (advance),
        .prev          (ew_prev),
        .bad_transition(ew_bad),
        .short_yellow  (ew_short),
        .green_timeout (ew_gto)
    );

    // The all-red counter measures the current "both red" / "not both red" episode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            allred_cnt <= '0;
        end else if (load) begin
            allred_cnt <= CW'(1);
        end else if (advance) begin
            if (all_red_now != all_red_prev) begin
                allred_cnt <= CW'(1);
            end else if (allred_cnt != '1) begin
                allred_cnt <= allred_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ARMING;
            ns_lamp    <= RED;
            ew_lamp    <= RED;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            flash_cnt  <= '0;
            flash_on   <= 1'b1;
        end else if (trip) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= cause;
            ns_lamp    <= RED;
            ew_lamp    <= RED;
            flash_cnt  <= '0;
            flash_on   <= 1'b1;
        end else begin
            case (state)
                ST_ARMING: begin
                    ns_lamp <= ns_light;
                    ew_lamp <= ew_light;
                    state   <= ST_MONITOR;
                end
                ST_MONITOR: begin
                    ns_lamp <= ns_light;
                    ew_lamp <= ew_light;
                end
                ST_FAULT: begin
                    if (clear_fault && inputs_ok) begin
                        state      <= ST_ARMING;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        ns_lamp    <= RED;
                        ew_lamp    <= RED;
                    end else if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        flash_on  <= !flash_on;
                        ns_lamp   <= flash_on ? DARK : RED;
                        ew_lamp   <= flash_on ? DARK : RED;
                    end else begin
                        flash_cnt <= flash_cnt + FW'(1);
                    end
                end
                default: state <= ST_ARMING;
            endcase
        end
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed scenarios plus random controller traffic vs a rule-level model.
module tb_light_conflict_monitor;
    import traffic_pkg::*;

    localparam int GMAX  = 51;
    localparam int YMIN  = 11;
    localparam int ARMAX = 4;
    localparam int FH    = 25;

    localparam int M_ARM = 0;
    localparam int M_MON = 1;
    localparam int M_FLT = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] ns_light, ew_light;
    logic       clear_fault;
    logic [2:0] ns_lamp, ew_lamp;
    logic       fault;
    logic [2:0] fault_code;

    always #5 clk = ~clk;

    light_conflict_monitor #(
        .GREEN_MAX  (GMAX),
        .YELLOW_MIN (YMIN),
        .ALL_RED_MAX(ARMAX),
        .FLASH_HALF (FH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .clear_fault(clear_fault),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks colours and episode lengths as plain integers.
    int         m_state;
    logic [2:0] m_pns, m_pew, m_lns, m_lew, m_code;
    bit         m_fault;
    int         m_dns, m_dew, m_dar, m_ticks;

    function automatic bit legal(input logic [2:0] c);
        return c == 3'b100 || c == 3'b010 || c == 3'b001;
    endfunction

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        if (c == GREEN)  return YELLOW;
        if (c == YELLOW) return RED;
        return GREEN;
    endfunction

    function automatic bit both_red(input logic [2:0] a, input logic [2:0] b);
        return a == RED && b == RED;
    endfunction

    task automatic model_reset();
        m_state = M_ARM; m_pns = RED; m_pew = RED; m_lns = RED; m_lew = RED;
        m_fault = 0; m_code = 0; m_dns = 0; m_dew = 0; m_dar = 0; m_ticks = 0;
    endtask

    task automatic model_trip(input int code);
        m_state = M_FLT; m_fault = 1; m_code = 3'(code);
        m_lns = RED; m_lew = RED; m_ticks = 0;
    endtask

    task automatic model_step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        int  code;
        bit  ok;
        ok = legal(ns) && legal(ew) && !(ns != RED && ew != RED);
        case (m_state)
            M_ARM: begin
                if (ok) begin
                    m_pns = ns; m_pew = ew; m_dns = 1; m_dew = 1; m_dar = 1;
                    m_lns = ns; m_lew = ew; m_state = M_MON;
                end else begin
                    model_trip(legal(ns) && legal(ew) ? 2 : 1);
                end
            end
            M_MON: begin
                code = 0;
                if (!(legal(ns) && legal(ew))) code = 1;
                else if (ns != RED && ew != RED) code = 2;
                else if ((ns != m_pns && ns != next_colour(m_pns)) ||
                         (ew != m_pew && ew != next_colour(m_pew))) code = 3;
                else if ((m_pns == YELLOW && ns == RED && m_dns < YMIN) ||
                         (m_pew == YELLOW && ew == RED && m_dew < YMIN)) code = 4;
                else if ((m_pns == GREEN && ns == GREEN && m_dns == GMAX) ||
                         (m_pew == GREEN && ew == GREEN && m_dew == GMAX)) code = 5;
                else if (both_red(ns, ew) && both_red(m_pns, m_pew) && m_dar == ARMAX) code = 6;
                if (code != 0) begin
                    model_trip(code);
                end else begin
                    m_dns = (ns == m_pns) ? m_dns + 1 : 1;
                    m_dew = (ew == m_pew) ? m_dew + 1 : 1;
                    m_dar = (both_red(ns, ew) == both_red(m_pns, m_pew)) ? m_dar + 1 : 1;
                    m_pns = ns; m_pew = ew; m_lns = ns; m_lew = ew;
                end
            end
            default: begin
                if (clr && ok) begin
                    m_state = M_ARM; m_fault = 0; m_code = 0; m_lns = RED; m_lew = RED;
                end else begin
                    m_ticks++;
                    m_lns = ((m_ticks / FH) % 2 == 0) ? RED : DARK;
                    m_lew = m_lns;
                end
            end
        endcase
    endtask

    task automatic compare(input string tag);
        check({tag, ".ns_lamp"}, 32'(ns_lamp), 32'(m_lns));
        check({tag, ".ew_lamp"}, 32'(ew_lamp), 32'(m_lew));
        check({tag, ".fault"}, 32'(fault), 32'(m_fault));
        check({tag, ".code"}, 32'(fault_code), 32'(m_code));
    endtask

    task automatic cycle(input string tag, input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        ns_light = ns; ew_light = ew; clear_fault = clr;
        @(posedge clk);
        model_step(ns, ew, clr);
        #1;
        compare(tag);
    endtask

    task automatic run(input string tag, input logic [2:0] ns, input logic [2:0] ew, input int n);
        for (int i = 0; i < n; i++) cycle(tag, ns, ew, 1'b0);
    endtask

    task automatic run_noise(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic hit_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check({tag, ".ns_lamp"}, 32'(ns_lamp), 32'(RED));
        check({tag, ".ew_lamp"}, 32'(ew_lamp), 32'(RED));
        check({tag, ".fault"}, 32'(fault), 32'd0);
        check({tag, ".code"}, 32'(fault_code), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int         r_phase, r_left;
    logic [2:0] r_ns, r_ew;

    function automatic int phase_len(input int p);
        if (p == 0 || p == 3) return $urandom_range(40, 53);
        if (p == 1 || p == 4) return $urandom_range(8, 13);
        return $urandom_range(0, 5);
    endfunction

    initial begin
        reset_n = 1'b1; ns_light = RED; ew_light = RED; clear_fault = 1'b0;
        model_reset();
        hit_reset("reset");

        // Nominal controller pattern, two full rotations.
        for (int r = 0; r < 2; r++) begin
            run("nominal", GREEN, RED, 51);
            run("nominal", YELLOW, RED, 11);
            run("nominal", RED, GREEN, 51);
            run("nominal", RED, YELLOW, 11);
        end
        check("nominal_end.fault", 32'(fault), 32'd0);
        check("nominal_end.ew_lamp", 32'(ew_lamp), 32'(YELLOW));

        // Conflict at cycle 20, then flash timing.
        hit_reset("reset2");
        run("pre_conflict", GREEN, RED, 19);
        cycle("conflict", GREEN, GREEN, 1'b0);
        check("conflict.code", 32'(fault_code), 32'd2);
        check("conflict.lamp", 32'(ns_lamp), 32'(RED));
        run_noise("flash_on", 24);
        check("flash24.lamp", 32'(ns_lamp), 32'(RED));
        run_noise("flash", 1);
        check("flash25.lamp", 32'(ns_lamp), 32'(DARK));
        run_noise("flash", 25);
        check("flash50.lamp", 32'(ew_lamp), 32'(RED));
        cycle("clear", GREEN, RED, 1'b1);
        check("clear.fault", 32'(fault), 32'd0);

        // Short yellow.
        run("sy_green", GREEN, RED, 10);
        run("sy_yellow", YELLOW, RED, 5);
        cycle("short_yellow", RED, GREEN, 1'b0);
        check("short_yellow.code", 32'(fault_code), 32'd4);
        cycle("clear", GREEN, RED, 1'b1);

        // Green timeout on the 52nd green sample.
        run("green51", GREEN, RED, 51);
        check("green51.fault", 32'(fault), 32'd0);
        cycle("green52", GREEN, RED, 1'b0);
        check("green52.code", 32'(fault_code), 32'd5);
        cycle("clear", GREEN, RED, 1'b1);

        // Invalid encoding and clear qualification.
        cycle("inv_arm", GREEN, RED, 1'b0);
        cycle("invalid", 3'b011, RED, 1'b0);
        check("invalid.code", 32'(fault_code), 32'd1);
        cycle("bad_clear", 3'b011, RED, 1'b1);
        check("bad_clear.fault", 32'(fault), 32'd1);
        cycle("good_clear", GREEN, RED, 1'b1);
        check("good_clear.fault", 32'(fault), 32'd0);
        cycle("rearm", GREEN, RED, 1'b0);
        check("rearm.ns_lamp", 32'(ns_lamp), 32'(GREEN));
        check("rearm.ew_lamp", 32'(ew_lamp), 32'(RED));

        // Illegal G->R, then reset while flashing.
        cycle("illegal", RED, RED, 1'b0);
        check("illegal.code", 32'(fault_code), 32'd3);
        run_noise("flash", 30);
        hit_reset("midflash_reset");

        // All-red limit: four samples fine, fifth trips.
        run("allred4", RED, RED, 4);
        check("allred4.fault", 32'(fault), 32'd0);
        cycle("allred5", RED, RED, 1'b0);
        check("allred5.code", 32'(fault_code), 32'd6);
        cycle("clear", RED, GREEN, 1'b1);

        // Random controller with occasional corruption, overruns and clears.
        r_phase = 0; r_left = phase_len(0);
        for (int i = 0; i < 3000; i++) begin
            while (r_left == 0) begin
                r_phase = (r_phase + 1) % 6;
                r_left  = phase_len(r_phase);
            end
            r_left--;
            case (r_phase)
                0: begin r_ns = GREEN;  r_ew = RED;    end
                1: begin r_ns = YELLOW; r_ew = RED;    end
                3: begin r_ns = RED;    r_ew = GREEN;  end
                4: begin r_ns = RED;    r_ew = YELLOW; end
                default: begin r_ns = RED; r_ew = RED; end
            endcase
            if ($urandom_range(0, 59) == 0) r_ns = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) r_ew = 3'($urandom_range(0, 7));
            cycle("random", r_ns, r_ew, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/light_conflict_monitor.md
# light_conflict_monitor

Safety checker on the receiving end of the controller's lamp-drive interface. It samples the `ns_light`/`ew_light` one-hot codes every cycle and checks four things:
- legal encoding;
- no conflicting right-of-way;
- legal colour sequence;
- phase dwell limits.

It forwards healthy codes to the lamp drivers. On the first violation it latches a fault code and forces both approaches into flashing red.

## Interface
- `GREEN_MAX`, default 51: maximum consecutive cycles one approach may show GREEN.
- `YELLOW_MIN`, default 11: minimum consecutive cycles of YELLOW before RED.
- `ALL_RED_MAX`, default 4: maximum consecutive cycles both approaches may be RED.
- `FLASH_HALF`, default 25: cycles per half-period of fault flashing.
- `clk`, in, 1: single clock; inputs are synchronous to it.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ns_light`, in, 3: NS code from the controller. RED=100, YELLOW=010, GREEN=001.
- `ew_light`, in, 3: EW code, same encoding.
- `clear_fault`, in, 1: single-cycle request to leave FAULT.
- `ns_lamp`, out, 3: registered NS lamp drive.
- `ew_lamp`, out, 3: registered EW lamp drive.
- `fault`, out, 1: latched fault flag.
- `fault_code`, out, 3: latched cause. 0=none, 1=invalid encoding, 2=conflict, 3=illegal transition, 4=short yellow, 5=green timeout, 6=all-red timeout.

## Operation
- **States:** ARMING, MONITOR, FAULT.
- **Reset values:**
  - state=ARMING;
  - `ns_lamp`=`ew_lamp`=100;
  - `fault`=0, `fault_code`=0;
  - dwell counters=0;
  - prev registers=100.
- **ARMING**, one edge:
  - Check encoding and conflict only.
  - If legal: load prev registers from inputs, set dwell counters to 1, drive lamps from inputs, go to MONITOR.
  - Otherwise go to FAULT.
- **MONITOR**, each edge, compare inputs against prev registers and dwell counters:
  - Invalid: either code is not exactly one of 100/010/001.
  - Conflict: both codes are non-RED.
  - Illegal transition: per approach, any change other than G→Y, Y→R or R→G.
  - Short yellow: Y→R with the yellow dwell count < `YELLOW_MIN`.
  - Green timeout: GREEN sampled while its dwell count == `GREEN_MAX`.
  - All-red timeout: both RED while the all-red count == `ALL_RED_MAX`.
- **Dwell counters:** a colour change loads 1; an unchanged colour increments. Counters saturate at all-ones, width `$clog2(GREEN_MAX+2)`. The all-red counter follows the same rule.
- **Priority when several checks fire on one edge:** code 1 > 2 > 3 > 4 > 5 > 6. Only the highest is latched.
- **Healthy edge:** lamps ← inputs, prev ← inputs.
- **Violation edge:** `fault`←1, `fault_code`←cause, lamps←100/100, flash counter←0, flash phase←on, go to FAULT. The offending code never reaches the lamps.
- **FAULT:**
  - Inputs are ignored except by the clear qualification below.
  - Flash counter counts 0..`FLASH_HALF`-1. At wrap, phase toggles: lamps alternate 100/100 (on) and 000/000 (off).
  - `fault_code` holds.
- **Clear:**
  - Taken only if `clear_fault`=1 in FAULT and current inputs are valid and non-conflicting. Then `fault`←0, `fault_code`←0, lamps←100/100, go to ARMING.
  - Otherwise the request is dropped and not remembered.
  - `clear_fault` outside FAULT has no effect.
- **Reset mid-operation:** all registers return to reset values immediately (asynchronous). There is no fault memory across reset.

## Timing
- Inputs sampled at edge N: lamps, `fault` and `fault_code` reflect them after edge N. Latency is one register.
- A violation on inputs before edge N gives `fault`=1 after edge N.
- After clear at edge N: ARMING during N..N+1. Lamps follow inputs after edge N+1.
- Flash half-period is exactly `FLASH_HALF` cycles. The first "on" phase starts at the violation edge.
- The dwell-limit defaults match a controller holding green 51 cycles and yellow 11 cycles, with no all-red gap.

## Structure
- Shared package `traffic_pkg` holds:
  - the colour constants RED/YELLOW/GREEN;
  - the fault-code constants;
  - the monitor state encoding.

  The controller imports the same colour constants.
- One sub-module, `approach_tracker`, instantiated twice (NS, EW). It contains the prev-colour register, the dwell counter, and the transition, short-yellow and green-timeout checks. It outputs the three check flags.
- Top level holds:
  - encoding and conflict checks;
  - the all-red counter;
  - priority encoding;
  - the FSM, flash counter and lamp registers.

## Test plan
- **Nominal:** controller-accurate pattern (NS G 51, NS Y 11, EW G 51, EW Y 11) for two full rotations → `fault`=0 throughout; lamps equal inputs delayed one cycle.
- **Conflict:** `ns_light`=`ew_light`=001 at cycle 20 → after that edge `fault`=1, code 2, lamps 100/100. Lamps go 000/000 after 25 more edges and 100/100 after 50.
- **Short yellow and green timeout:**
  - NS yellow held 5 cycles then R → code 4.
  - Separately, NS green held 52 cycles → code 5 on the 52nd green sample.
- **Invalid encoding and clear qualification:**
  - `ns_light`=011 → code 1.
  - `clear_fault` while still 011 → stays FAULT.
  - Apply NS=001, EW=100 and `clear_fault` → `fault`=0. Lamps 001/100 one edge after ARMING.
- **Illegal transition and reset:**
  - NS G→R directly with EW held R → code 3.
  - Assert `reset_n`=0 mid-flash → lamps 100/100, `fault`=0 without waiting for a clock edge.
